// File: rtl/addkey_sched_if.sv
// Handshake bundle for the AddRoundKey stage: key load, upstream state input, downstream keyed output.
interface addkey_sched_if #(
  parameter int NK = 4
);
  logic              key_load;
  logic [32*NK-1:0]  key_in;
  logic [127:0]      state_in;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      out_data;
  logic [3:0]        out_round;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output key_load, key_in, state_in, in_valid, out_ready,
    input  in_ready, out_data, out_round, out_last, out_valid
  );

  modport slave (
    input  key_load, key_in, state_in, in_valid, out_ready,
    output in_ready, out_data, out_round, out_last, out_valid
  );
endinterface

// File: rtl/addkey_sched.sv
// AddRoundKey stage with a word-serial AES-128/192/256 key schedule.
// One expanded key word per cycle fills rk_acc; a finished round key waits in rk_cur.
module addkey_sched #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  addkey_sched_if.slave bus
);
  localparam int NR    = NK + 6;
  localparam int KEY_W = 32 * NK;
  localparam int LAST  = 4 * (NR + 1) - 1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] inv;
    s   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s   = gmul(s, s);
      inv = gmul(inv, s);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [KEY_W-1:0] key_reg;
  logic             key_valid;
  logic [31:0]      win [NK];
  logic [5:0]       widx;
  logic [2:0]       kmod;
  logic [7:0]       rcon;
  logic             gen_on;
  logic [127:0]     rk_acc;
  logic [1:0]       acc_cnt;
  logic             acc_full;
  logic [127:0]     rk_cur;
  logic             cur_valid;
  logic [3:0]       round;

  logic             accept;
  logic             cur_free;
  logic             gen_step;
  logic [31:0]      key_words [8];
  logic [31:0]      t;
  logic [31:0]      new_word;

  assign bus.in_ready = key_valid & cur_valid & (~bus.out_valid | bus.out_ready) & ~bus.key_load;
  assign accept       = bus.in_valid & bus.in_ready;
  assign cur_free     = ~cur_valid | accept;
  assign gen_step     = gen_on & (~acc_full | cur_free);

  // Generator stage: next schedule word from the NK-word window.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_words[j] = key_reg[KEY_W-1-32*(j%NK) -: 32];
    end
    t        = win[NK-1];
    new_word = key_words[widx[2:0]];
    if (widx >= 6'(NK)) begin
      if (kmod == 3'd0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
      end else if (NK == 8 && kmod == 3'd4) begin
        t = sub_word(t);
      end
      new_word = win[0] ^ t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid     <= 1'b0;
      gen_on        <= 1'b0;
      widx          <= '0;
      kmod          <= '0;
      rcon          <= 8'h01;
      acc_cnt       <= '0;
      acc_full      <= 1'b0;
      cur_valid     <= 1'b0;
      round         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_round <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      // Output stage: state XOR round key, held while downstream stalls.
      if (accept) begin
        bus.out_data  <= bus.state_in ^ rk_cur;
        bus.out_round <= round;
        bus.out_last  <= (round == 4'(NR));
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (bus.key_load) begin
        key_reg   <= bus.key_in;
        key_valid <= 1'b1;
        gen_on    <= 1'b1;
        widx      <= '0;
        kmod      <= '0;
        rcon      <= 8'h01;
        acc_cnt   <= '0;
        acc_full  <= 1'b0;
        cur_valid <= 1'b0;
        round     <= '0;
      end else begin
        if (accept) begin
          cur_valid <= 1'b0;
          round     <= (round == 4'(NR)) ? 4'd0 : round + 4'd1;
        end
        if (acc_full && cur_free) begin
          rk_cur    <= rk_acc;
          cur_valid <= 1'b1;
          acc_full  <= 1'b0;
        end
        if (gen_step) begin
          for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
          win[NK-1] <= new_word;
          if (widx >= 6'(NK) && kmod == 3'd0) rcon <= xtime(rcon);
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          widx <= widx + 6'd1;
          if (widx == 6'(LAST)) gen_on <= 1'b0;
          case (acc_cnt)
            2'd0: rk_acc[127:96] <= new_word;
            2'd1: rk_acc[95:64]  <= new_word;
            2'd2: rk_acc[63:32]  <= new_word;
            default: begin
              // A completed key skips rk_acc when rk_cur is (or is becoming) free.
              if (cur_free) begin
                rk_cur    <= {rk_acc[127:32], new_word};
                cur_valid <= 1'b1;
              end else begin
                rk_acc   <= {rk_acc[127:32], new_word};
                acc_full <= 1'b1;
              end
            end
          endcase
          acc_cnt <= acc_cnt + 2'd1;
        end
        // Last round key consumed: rerun the schedule from the stored key.
        if (accept && round == 4'(NR)) begin
          gen_on <= 1'b1;
          widx   <= '0;
          kmod   <= '0;
          rcon   <= 8'h01;
        end
      end
    end
  end
endmodule

// File: tb/tb_addkey_sched.sv
// Bench for addkey_sched: AES-128/192/256 instances against a key-expansion model and output scoreboard.
module tb_addkey_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        kl, iv, orr;
  logic [2:0][127:0] st;
  logic [2:0][255:0] key;
  logic [2:0]        ir, ov, ol;
  logic [2:0][127:0] od;
  logic [2:0][3:0]   orn;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NKG = 4 + 2 * g;
    addkey_sched_if #(.NK(NKG)) bus ();
    assign bus.key_load  = kl[g];
    assign bus.key_in    = key[g][32*NKG-1:0];
    assign bus.state_in  = st[g];
    assign bus.in_valid  = iv[g];
    assign bus.out_ready = orr[g];
    assign ir[g]  = bus.in_ready;
    assign od[g]  = bus.out_data;
    assign orn[g] = bus.out_round;
    assign ol[g]  = bus.out_last;
    assign ov[g]  = bus.out_valid;
    addkey_sched #(.NK(NKG)) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] R1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] R10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [191:0] K192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
  localparam logic [255:0] K256 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  logic [7:0]   sb [256];
  logic [127:0] rk_mdl [3][15];
  bit           exp_v [3];
  logic [127:0] exp_d [3];
  int           exp_r [3];
  bit           exp_l [3];
  int           mround [3];
  bit           key_ok [3];

  task automatic chk(input string nm, input int g, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, g, act, exp);
    end
  endtask

  // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        sb[a][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    end
  endtask

  task automatic load_model(input int g, input logic [255:0] k);
    int nk;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nk = 4 + 2 * g;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = 32'(k >> (32 * (nk - 1 - i)));
      else begin
        t = w[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk + 6; r++) rk_mdl[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Scoreboard: what each output register must hold after this edge.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        exp_v[g] = 0; exp_d[g] = '0; exp_r[g] = 0; exp_l[g] = 0; mround[g] = 0; key_ok[g] = 0;
      end else begin
        if (iv[g] && ir[g]) begin
          exp_d[g]  = st[g] ^ rk_mdl[g][mround[g]];
          exp_r[g]  = mround[g];
          exp_l[g]  = (mround[g] == 10 + 2 * g);
          exp_v[g]  = 1;
          mround[g] = (mround[g] == 10 + 2 * g) ? 0 : mround[g] + 1;
        end else if (orr[g]) exp_v[g] = 0;
        if (kl[g]) begin key_ok[g] = 1; mround[g] = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int g = 0; g < 3; g++) begin
        chk("out_valid", g, ov[g], exp_v[g]);
        if (exp_v[g]) begin
          chk("out_data", g, od[g], exp_d[g]);
          chk("out_round", g, orn[g], exp_r[g]);
          chk("out_last", g, ol[g], exp_l[g]);
        end
        if (ir[g]) chk("in_ready_gate", g, ir[g], key_ok[g] && !(exp_v[g] && !orr[g]) && !kl[g]);
      end
    end
  end

  task automatic do_load(input int g, input logic [255:0] k);
    key[g] = k;
    load_model(g, k);
    kl[g] = 1'b1;
    @(posedge clk); #1;
    kl[g] = 1'b0;
  endtask

  task automatic accept_one(input int g, input logic [127:0] s, output logic [127:0] d,
                            output int r, output bit l);
    int n;
    st[g] = s; iv[g] = 1'b1; orr[g] = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ir[g] && n < 40);
    chk("accept_seen", g, ir[g], 1'b1);
    @(posedge clk); #1;
    iv[g] = 1'b0;
    @(negedge clk);
    d = od[g]; r = int'(orn[g]); l = ol[g];
    @(posedge clk); #1;
  endtask

  task automatic stream(input int g, input int n, input bit gapchk);
    int got, gap;
    got = 0; gap = 0;
    iv[g] = 1'b1; orr[g] = 1'b1; st[g] = rand128();
    while (got < n && gap < 40) begin
      @(negedge clk); gap++;
      if (ir[g]) begin
        if (gapchk && got > 0 && mround[g] != 0) chk("accept_gap", g, gap, 4);
        got++; gap = 0;
        @(posedge clk); #1;
        st[g] = rand128();
      end else begin
        @(posedge clk); #1;
      end
    end
    iv[g] = 1'b0;
    chk("stream_accepts", g, got, n);
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      for (int g = 0; g < 3; g++) begin
        iv[g]  = ($urandom_range(0, 3) != 0);
        orr[g] = ($urandom_range(0, 3) != 0);
        st[g]  = rand128();
        kl[g]  = ($urandom_range(0, 249) == 0);
        if (kl[g]) begin key[g] = rand256(); load_model(g, key[g]); end
      end
      @(posedge clk); #1;
    end
    kl = '0; iv = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d_arr [11];
    bit           l_arr [11];
    int           r_arr [11];
    logic [127:0] d, s, held;
    int           r, nacc;
    bit           l;

    rst = 1'b1; kl = '0; iv = '0; orr = '0; st = '0; key = '0;
    build_sbox();
    chk("model_sbox00", 0, sb[8'h00], 8'h63);
    chk("model_sbox53", 0, sb[8'h53], 8'hed);
    load_model(0, 256'(K128));
    chk("model_k128_r1", 0, rk_mdl[0][1], R1);
    chk("model_k128_r10", 0, rk_mdl[0][10], R10);
    load_model(1, 256'(K192));
    chk("model_k192_r1w0", 1, rk_mdl[1][1][127:96], 32'h62f8ead2);
    chk("model_k192_r1w2", 1, rk_mdl[1][1][63:32], 32'hfe0c91f7);
    load_model(2, K256);
    chk("model_k256_r2", 2, rk_mdl[2][2], 128'ha573c29f_a176c498_a97fce93_a572c09c);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_out_data", g, od[g], '0);
      chk("reset_in_ready", g, ir[g], 1'b0);
    end
    @(posedge clk); #1;

    // AES-128 vector, first-key latency, full round sequence with zero states
    orr[0] = 1'b1;
    do_load(0, 256'(K128));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("first_key_latency", 0, ir[0], (k == 4));
      if (k < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) accept_one(0, '0, d_arr[i], r_arr[i], l_arr[i]);
    chk("aes128_r0", 0, d_arr[0], K128);
    chk("aes128_r1", 0, d_arr[1], R1);
    chk("aes128_r10", 0, d_arr[10], R10);
    chk("aes128_round10", 0, r_arr[10], 10);
    chk("aes128_last10", 0, l_arr[10], 1'b1);
    chk("aes128_last9", 0, l_arr[9], 1'b0);

    // wrap to round 0 without key_load
    s = rand128();
    accept_one(0, s, d, r, l);
    chk("wrap_data", 0, d, s ^ K128);
    chk("wrap_round", 0, r, 0);

    // downstream stall: one accept, held output, then resume
    orr[0] = 1'b0; iv[0] = 1'b1; st[0] = rand128(); nacc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ir[0]) nacc++;
      @(posedge clk); #1;
    end
    chk("stall_accepts", 0, nacc, 1);
    @(negedge clk);
    held = od[0];
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("stall_hold", 0, od[0], held);
    chk("stall_valid", 0, ov[0], 1'b1);
    @(posedge clk); #1;
    stream(0, 3, 1'b0);

    // steady-state throughput from a fresh key
    do_load(0, rand256());
    stream(0, 11, 1'b1);

    // key_load in the middle of round 5 generation
    do_load(0, rand256());
    stream(0, 5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_load(0, 256'(K128));
    accept_one(0, '0, d, r, l);
    chk("reload_data", 0, d, K128);
    chk("reload_round", 0, r, 0);

    // AES-192 and AES-256 vectors
    do_load(1, 256'(K192));
    accept_one(1, '0, d, r, l);
    accept_one(1, '0, d, r, l);
    chk("aes192_r1w0", 1, d[127:96], 32'h62f8ead2);
    chk("aes192_r1w2", 1, d[63:32], 32'hfe0c91f7);
    do_load(2, K256);
    for (int i = 0; i < 3; i++) accept_one(2, '0, d, r, l);
    chk("aes256_r2", 2, d, 128'ha573c29f_a176c498_a97fce93_a572c09c);
    chk("aes256_round", 2, r, 2);

    // randomized traffic, reset mid-run, more randomized traffic
    for (int g = 0; g < 3; g++) do_load(g, rand256());
    rand_phase(700);
    iv = '1; orr = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv = '0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_valid", g, ov[g], 1'b0);
      chk("rst_out_data", g, od[g], '0);
      chk("rst_out_round", g, orn[g], '0);
      chk("rst_out_last", g, ol[g], 1'b0);
      chk("rst_in_ready", g, ir[g], 1'b0);
    end
    @(posedge clk); #1;
    orr = '1;
    for (int g = 0; g < 3; g++) do_load(g, rand256());
    rand_phase(700);
    orr = '1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
